// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: EX operand forwarding selects (0 decode, 1 mem, 2 wb), load-use stall/bubble, saturating stall counter; ports: clk, rst, pipe_freeze, flush_id, id_* in, reg1_sel/reg2_sel/ST_reg_sel, stall_ifid, bubble_ex, stall_count out
module forward_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_freeze,
  input  logic                  flush_id,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rst,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_st_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  output logic [1:0]            reg1_sel,
  output logic [1:0]            reg2_sel,
  output logic [1:0]            ST_reg_sel,
  output logic                  stall_ifid,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      stall_count
);
  logic ex_v, ex_we, ex_ld, mem_v, mem_we, mem_ld, ex_w, mem_w, hazard;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic [REG_ADDR_W+2:0] wb_unused;
  logic [2:0][REG_ADDR_W-1:0] src;
  logic [2:0] used, ex_hit, mem_hit;
  logic [2:0][1:0] sel_n, sel;
  assign src = {id_rst, id_rs2, id_rs1};
  assign used = {id_st_used, id_rs2_used, id_rs1_used};
  assign ex_w = ex_v && ex_we && !(ZERO_REG && ex_rd == '0);
  assign mem_w = mem_v && mem_we && !(ZERO_REG && mem_rd == '0);
  genvar i;
  for (i = 0; i < 3; i++) begin : g_op
    assign ex_hit[i] = used[i] && ex_w && ex_rd == src[i];
    assign mem_hit[i] = used[i] && mem_w && mem_rd == src[i];
    assign sel_n[i] = (ex_hit[i] && !ex_ld) ? 2'd1 : mem_hit[i] ? 2'd2 : 2'd0;
  end
  assign hazard = id_valid && !flush_id && ex_ld && |ex_hit;
  assign stall_ifid = !rst && !pipe_freeze && hazard;
  assign bubble_ex = !rst && !pipe_freeze && (hazard || flush_id);
  assign reg1_sel = sel[0];
  assign reg2_sel = sel[1];
  assign ST_reg_sel = sel[2];
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v <= 1'b0;
      ex_rd <= '0;
      ex_we <= 1'b0;
      ex_ld <= 1'b0;
      mem_v <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      mem_ld <= 1'b0;
      wb_unused <= '0;
      sel <= '0;
      stall_count <= '0;
    end else if (!pipe_freeze) begin
      wb_unused <= {mem_v, mem_rd, mem_we, mem_ld};
      mem_v <= ex_v;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      ex_v <= id_valid && !bubble_ex;
      ex_rd <= id_rd;
      ex_we <= id_we;
      ex_ld <= id_is_load;
      sel <= bubble_ex ? '0 : sel_n;
      if (stall_ifid && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb_forward_hazard_ctrl: scoreboard bench with a queue-based pipeline history model
module tb_forward_hazard_ctrl;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst, pipe_freeze, flush_id, id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rst, id_rd;
  logic id_rs1_used, id_rs2_used, id_st_used, id_we, id_is_load;
  logic [1:0] reg1_sel, reg2_sel, ST_reg_sel;
  logic stall_ifid, bubble_ex;
  logic [CW-1:0] stall_count;
  always #5 clk = ~clk;
  forward_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .pipe_freeze(pipe_freeze), .flush_id(flush_id),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rst(id_rst),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_st_used(id_st_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .reg1_sel(reg1_sel), .reg2_sel(reg2_sel), .ST_reg_sel(ST_reg_sel),
    .stall_ifid(stall_ifid), .bubble_ex(bubble_ex), .stall_count(stall_count)
  );
  typedef struct {logic v; logic [AW-1:0] rd; logic we; logic ld;} ins_t;
  typedef struct {logic [1:0] s1; logic [1:0] s2; logic [1:0] s3; int cnt;} exp_t;
  ins_t hist[$];
  exp_t sbq[$];
  exp_t cur;
  int tests = 0;
  int fails = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic bit wr(int k, logic [AW-1:0] r);
    if (k >= hist.size()) return 1'b0;
    return hist[k].v && hist[k].we && hist[k].rd != 0 && hist[k].rd == r;
  endfunction
  function automatic logic [1:0] pick(bit u, logic [AW-1:0] r);
    if (!u) return 2'd0;
    if (wr(0, r) && !hist[0].ld) return 2'd1;
    if (wr(1, r)) return 2'd2;
    return 2'd0;
  endfunction
  task automatic step(bit r, bit fz, bit fl, bit v, logic [AW-1:0] a, logic [AW-1:0] b,
                      logic [AW-1:0] c, bit ua, bit ub, bit uc, logic [AW-1:0] d,
                      bit w, bit l, output bit took);
    bit haz, st, bb;
    ins_t n;
    rst = r; pipe_freeze = fz; flush_id = fl; id_valid = v;
    id_rs1 = a; id_rs2 = b; id_rst = c;
    id_rs1_used = ua; id_rs2_used = ub; id_st_used = uc;
    id_rd = d; id_we = w; id_is_load = l;
    #1;
    haz = v && !fl && hist.size() > 0 && hist[0].ld &&
          ((ua && wr(0, a)) || (ub && wr(0, b)) || (uc && wr(0, c)));
    st = !r && !fz && haz;
    bb = !r && !fz && (haz || fl);
    chk("stall_ifid", stall_ifid, st);
    chk("bubble_ex", bubble_ex, bb);
    if (r) begin
      hist.delete();
      cur = '{2'd0, 2'd0, 2'd0, 0};
    end else if (!fz) begin
      cur.s1 = bb ? 2'd0 : pick(ua, a);
      cur.s2 = bb ? 2'd0 : pick(ub, b);
      cur.s3 = bb ? 2'd0 : pick(uc, c);
      if (st && cur.cnt < CMAX) cur.cnt++;
      n.v = v && !bb; n.rd = d; n.we = w; n.ld = l;
      hist.push_front(n);
      if (hist.size() > 3) void'(hist.pop_back());
    end
    took = !r && !fz && !st;
    sbq.push_back(cur);
    @(posedge clk);
    #2;
  endtask
  task automatic go(bit v, logic [AW-1:0] a, bit ua, logic [AW-1:0] b, bit ub,
                    logic [AW-1:0] c, bit uc, logic [AW-1:0] d, bit w, bit l,
                    bit fl = 1'b0, bit fz = 1'b0);
    bit t;
    step(1'b0, fz, fl, v, a, b, c, ua, ub, uc, d, w, l, t);
  endtask
  task automatic nop();
    go(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("reg1_sel", reg1_sel, e.s1);
        chk("reg2_sel", reg2_sel, e.s2);
        chk("ST_reg_sel", ST_reg_sel, e.s3);
        chk("stall_count", stall_count, e.cnt);
      end
    end
  end
  initial begin
    bit t, took;
    bit r, fz, fl, v, ua, ub, uc, w, l;
    logic [AW-1:0] a, b, c, d;
    cur = '{2'd0, 2'd0, 2'd0, 0};
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1,
           4'($urandom), 1, 1, t);
    go(1, 1, 1, 1, 1, 0, 0, 3, 1, 0);
    go(1, 3, 1, 5, 1, 0, 0, 6, 1, 0);
    nop(); nop();
    go(1, 1, 1, 2, 1, 0, 0, 4, 1, 0);
    nop();
    go(1, 4, 1, 0, 0, 0, 0, 9, 1, 0);
    nop(); nop();
    go(1, 1, 1, 2, 1, 0, 0, 4, 1, 0);
    go(1, 1, 1, 2, 1, 0, 0, 4, 1, 0);
    go(1, 4, 1, 4, 1, 0, 0, 9, 1, 0);
    nop(); nop();
    go(1, 1, 1, 0, 0, 0, 0, 7, 1, 1);
    go(1, 1, 1, 7, 1, 0, 0, 8, 1, 0);
    go(1, 1, 1, 7, 1, 0, 0, 8, 1, 0);
    nop(); nop();
    go(1, 1, 1, 1, 1, 0, 0, 2, 1, 0);
    go(1, 5, 1, 0, 0, 2, 1, 0, 0, 0);
    nop(); nop();
    go(1, 1, 1, 1, 1, 0, 0, 0, 1, 0);
    go(1, 0, 1, 0, 1, 0, 1, 5, 1, 0);
    go(1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    go(1, 0, 1, 0, 1, 0, 1, 5, 1, 0);
    nop(); nop();
    go(1, 1, 1, 0, 0, 0, 0, 7, 1, 1);
    for (int i = 0; i < 3; i++) go(1, 7, 1, 2, 1, 0, 0, 8, 1, 0, 0, 1);
    go(1, 7, 1, 2, 1, 0, 0, 8, 1, 0);
    go(1, 7, 1, 2, 1, 0, 0, 8, 1, 0);
    nop(); nop();
    go(1, 1, 1, 0, 0, 0, 0, 7, 1, 1);
    go(1, 7, 1, 2, 1, 0, 0, 8, 1, 0, 1);
    nop(); nop();
    go(1, 1, 1, 0, 0, 0, 0, 7, 1, 1);
    go(1, 7, 1, 0, 0, 0, 0, 8, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 7, 0, 0, 1, 0, 0, 8, 1, 0, t);
    go(1, 7, 1, 0, 0, 0, 0, 8, 1, 0);
    nop(); nop();
    for (int i = 0; i < 20; i++) begin
      go(1, 2, 1, 0, 0, 0, 0, 1, 1, 1);
      go(1, 1, 1, 1, 1, 1, 1, 3, 1, 0);
      go(1, 1, 1, 1, 1, 1, 1, 3, 1, 0);
    end
    took = 1'b1;
    {r, fz, fl, v, ua, ub, uc, w, l} = '0;
    {a, b, c, d} = '0;
    for (int i = 0; i < 800; i++) begin
      if (took) begin
        v = $urandom_range(0, 7) != 0;
        a = 4'($urandom_range(0, 7)); b = 4'($urandom_range(0, 7));
        c = 4'($urandom_range(0, 7)); d = 4'($urandom_range(0, 7));
        ua = 1'($urandom); ub = 1'($urandom); uc = 1'($urandom);
        w = $urandom_range(0, 3) != 0; l = $urandom_range(0, 2) == 0;
      end
      r = $urandom_range(0, 59) == 0;
      fz = $urandom_range(0, 7) == 0;
      fl = $urandom_range(0, 9) == 0;
      step(r, fz, fl, v, a, b, c, ua, ub, uc, d, w, l, took);
      took = took || fl;
    end
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/forward_hazard_ctrl.md
Name: forward_hazard_ctrl

Overview:
Forwarding and hazard controller for the 4-stage-backend pipeline (ID -> EX -> MEM -> WB). It tracks destination registers of in-flight instructions and drives the three 2-bit operand-source selects of the execute stage (0 = decode operand, 1 = mem_result, 2 = wb_result). It detects load-use hazards, stalls IF/ID and inserts an EX bubble. It also keeps a stall performance counter.

Parameters:
REG_ADDR_W, 4, register address width
CNT_W, 32, width of stall performance counter
ZERO_REG, 1, if 1 register 0 is hardwired zero and never forwarded/hazarded

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pipe_freeze  in  1  global freeze (memory wait); all state holds
flush_id  in  1  kill instruction currently in ID (branch taken)
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2, id_rst  in  REG_ADDR_W  ALU source 1, ALU source 2, store-data register
id_rs1_used, id_rs2_used, id_st_used  in  1  corresponding operand actually read
id_rd  in  REG_ADDR_W  ID destination register
id_we  in  1  ID instruction writes id_rd
id_is_load  in  1  ID instruction is a load
reg1_sel, reg2_sel, ST_reg_sel  out  2  registered operand selects for the instruction now in EX
stall_ifid  out  1  hold PC and IF/ID register this cycle (combinational)
bubble_ex  out  1  load NOP into ID/EX this cycle (combinational)
stall_count  out  CNT_W  number of load-use stall cycles since reset

Behaviour:
- Internal slots EX, MEM, WB, each {valid, rd, we, ld}. WB slot is kept for debug and visibility only.
- Regfile writes in WB and is readable the same cycle, so distance-3 needs no forwarding.
- A slot "writes r" when valid && we && !(ZERO_REG && rd==0).
- hazard (combinational) = id_valid && !flush_id && EX slot writes r && EX.ld, where r matches any used source (rs1/rs2/rst with its _used flag).
- stall_ifid = hazard && !pipe_freeze.
- bubble_ex = (hazard || flush_id) && !pipe_freeze.
- flush_id and hazard together: flush wins. The instruction is killed, stall_ifid=0, bubble_ex=1.
- Per-operand next select, evaluated for ID operands against the current slots. Unused operand or zero register -> 0.
  - EX slot writes r and !EX.ld -> 1. In the next cycle EX moves to MEM, so its ALU result is mem_result.
  - Else MEM slot writes r -> 2. That instruction is in WB next cycle. This covers a load that has already passed one stall cycle.
  - Else 0.
  - Nearest producer has priority: EX match beats MEM match.
- Clock edge with rst=1:
  - all slots invalid
  - reg1_sel = reg2_sel = ST_reg_sel = 0
  - stall_count = 0
  - stall_ifid and bubble_ex = 0, because id_valid is ignored during reset.
- Clock edge with pipe_freeze=1: all slots, selects and counter hold. Combinational outputs are 0.
- Other clock edges, in order:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble_ex ? invalid : {id_valid, id_rd, id_we, id_is_load}.
  - Selects <= bubble_ex ? 0 : next selects.
  - stall_count increments when stall_ifid. It saturates at all-ones, with no wrap.
- Latency: selects valid one cycle after the consumer is in ID, i.e. throughout its EX cycle. Stall outputs have zero latency.
- Reset mid-stall: the stall drops immediately. A pending load is forgotten, and the resumed instruction after reset sees select 0.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 and random regs -> all selects 0, stall_count 0, stall_ifid 0.
- ALU back-to-back: ADD r3 (we) then SUB rs1=r3, rs2=r5 -> SUB in EX sees reg1_sel=1, reg2_sel=0, no stall.
- Distance 2 plus priority:
  - ADD r4, then NOP, then use r4 -> select 2.
  - ADD r4, ADD r4, use rs1=r4 -> select 1 (nearest wins).
- Load-use: LD r7 then ADD rs2=r7 -> exactly 1 cycle with stall_ifid=1 and bubble_ex=1. Then ADD enters EX with reg2_sel=2. stall_count=1.
- Store data and zero register:
  - ADD r2 then ST with rst=r2 -> ST_reg_sel=1.
  - Producer writes r0, consumer reads r0 -> select 0, no stall.
- Freeze and flush:
  - Load-use pending while pipe_freeze=1 for 3 cycles -> no stall output, state and counter held. Stall resumes on release.
  - flush_id during load-use -> stall_ifid=0, bubble_ex=1, count unchanged.
